phy_tx_stripe: RTL

PHY_TX_STRIPE -- requirements
Module: phy_tx_stripe

---
 rtl/phy_tx_stripe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/phy_tx_stripe.sv
// phy_tx_stripe: stripes parallel words byte-wise across LANES serial lanes.
// One word period lasts PERIOD = DATA_W/LANES cycles of clk_32f; a new word
// (or a fill word when nothing is offered) is loaded at the last cycle of
// each period and shifted out MSB first starting on the very next cycle.
// Optional build macro: PHY_TX_IDLE_COM_EN selects the COM symbol (8'hBC)
// as the fill byte instead of 8'h00.
module phy_tx_stripe #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LANES-1:0]  data_out,
  output logic              idle_out
);

  localparam int PERIOD = DATA_W / LANES;
  localparam int SLOTS  = PERIOD / 8;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

`ifdef PHY_TX_IDLE_COM_EN
  localparam logic [7:0] FILL_BYTE = 8'hBC;
`else
  localparam logic [7:0] FILL_BYTE = 8'h00;
`endif

  // Reject lane counts and widths that cannot be striped into whole bytes.
  generate
    if (!((LANES == 1) || (LANES == 2) || (LANES == 4)) ||
        ((DATA_W % (8 * LANES)) != 0) || (PERIOD < 8)) begin : g_param_check
      $error("phy_tx_stripe: illegal DATA_W/LANES combination");
    end
  endgenerate

  typedef enum logic {
    FILL = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              primed;
  logic [CNT_W-1:0]  cnt;
  logic              load;
  logic [DATA_W-1:0] src_word;
  logic [PERIOD-1:0] shreg    [LANES];
  logic [PERIOD-1:0] load_val [LANES];

  // The load slot is the last cycle of the period; reset masks it so no
  // word can be accepted while the block is held in reset.
  always_comb begin
    load = (cnt == CNT_MAX) && !reset;
  end

  // Pick the word to launch: offered data, or a word made of fill bytes.
  always_comb begin
    src_word = {(DATA_W / 8){FILL_BYTE}};
    if (valid_in) begin
      src_word = data_in;
    end
  end

  // Byte k goes to lane k mod LANES, slot k div LANES; slot 0 sits in the
  // top byte of each lane register so it is shifted out first.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      load_val[l] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        load_val[l][PERIOD-1-8*s -: 8] = src_word[DATA_W-1-8*(s*LANES+l) -: 8];
      end
    end
  end

  // Free-running period counter; reset parks it on the load slot so the
  // first cycle after release can accept a word.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt <= CNT_MAX;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Per-lane shift registers: parallel load at the slot, otherwise shift
  // left one bit per cycle; reset throws away anything in flight.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        shreg[l] <= '0;
      end
    end else if (load) begin
      for (int l = 0; l < LANES; l++) begin
        shreg[l] <= load_val[l];
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        shreg[l] <= {shreg[l][PERIOD-2:0], 1'b0};
      end
    end
  end

  // Each lane drives the MSB of its shift register.
  always_comb begin
    data_out = '0;
    for (int l = 0; l < LANES; l++) begin
      data_out[l] = shreg[l][PERIOD-1];
    end
  end

  // State register; primed records that at least one period has been
  // launched since reset so idle_out stays low until then.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state  <= FILL;
      primed <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        primed <= 1'b1;
      end
    end
  end

  // Next state is chosen only at the load slot, from valid_in.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = valid_in ? DATA : FILL;
    end
  end

  // Outputs: ready on the load slot, idle while a fill period is on the wire.
  always_comb begin
    ready_out = load;
    idle_out  = primed && (state == FILL);
  end

endmodule
